// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit that issues PC requests under a credit rule and buffers in-order responses for decode.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_3000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);
    localparam logic [3:0] FD = 4'(FIFO_DEPTH);
    localparam logic [2:0] MO = 3'(MAX_OUTSTANDING);
    localparam logic [2:0] FL = 3'(FIFO_DEPTH - 1);
    localparam logic [1:0] TL = 2'(MAX_OUTSTANDING - 1);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [2:0]  outstanding_q, outstanding_d;
    logic [2:0]  discard_q, discard_d;
    logic [31:0] tag_q [4];
    logic [31:0] tag_d [4];
    logic [1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [31:0] fifo_pc_q [8];
    logic [31:0] fifo_pc_d [8];
    logic [31:0] fifo_instr_q [8];
    logic [31:0] fifo_instr_d [8];
    logic [2:0]  wr_q, wr_d, rd_q, rd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant, acc, push, pop;
    logic        unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];
    assign imem_req  = !reset && !redirect && outstanding_q < MO && 4'(outstanding_q) + cnt_q < FD;
    assign imem_addr = fetch_pc_q;
    assign out_valid = cnt_q != 4'd0 && !redirect && !reset;
    assign out_pc    = out_valid ? fifo_pc_q[rd_q] : 32'd0;
    assign out_instr = out_valid ? fifo_instr_q[rd_q] : 32'd0;

    // next-state: PC advance/redirect, credit counters, tag queue and instruction buffer
    always_comb begin
        grant         = imem_req && imem_gnt;
        acc           = imem_rvalid && outstanding_q != 3'd0;
        push          = acc && discard_q == 3'd0 && !redirect;
        pop           = out_valid && out_ready;
        fetch_pc_d    = redirect ? {redirect_pc[31:2], 2'b00} : grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
        outstanding_d = outstanding_q + 3'(grant) - 3'(acc);
        discard_d     = redirect ? outstanding_q - 3'(acc) : (acc && discard_q != 3'd0) ? discard_q - 3'd1 : discard_q;
        tag_d         = tag_q;
        if (grant) tag_d[tag_wr_q] = fetch_pc_q;
        tag_wr_d      = grant ? (tag_wr_q == TL ? 2'd0 : tag_wr_q + 2'd1) : tag_wr_q;
        tag_rd_d      = acc ? (tag_rd_q == TL ? 2'd0 : tag_rd_q + 2'd1) : tag_rd_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;
        if (push) fifo_pc_d[wr_q] = tag_q[tag_rd_q];
        if (push) fifo_instr_d[wr_q] = imem_rdata;
        wr_d          = redirect ? 3'd0 : push ? (wr_q == FL ? 3'd0 : wr_q + 3'd1) : wr_q;
        rd_d          = redirect ? 3'd0 : pop ? (rd_q == FL ? 3'd0 : rd_q + 3'd1) : rd_q;
        cnt_d         = redirect ? 4'd0 : cnt_q + 4'(push) - 4'(pop);
    end

    // control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= 3'd0;
            discard_q     <= 3'd0;
            tag_wr_q      <= 2'd0;
            tag_rd_q      <= 2'd0;
            wr_q          <= 3'd0;
            rd_q          <= 3'd0;
            cnt_q         <= 4'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            cnt_q         <= cnt_d;
        end
    end

    // storage arrays need no reset; emptiness is tracked by the counters
    always_ff @(posedge clk) begin
        tag_q        <= tag_d;
        fifo_pc_q    <= fifo_pc_d;
        fifo_instr_q <= fifo_instr_d;
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench with a queue-based fetch model and an in-order memory model.
module tb_ifu_fetch;
    localparam int FD = 2;
    localparam int MO = 2;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, redirect, imem_gnt, imem_rvalid, out_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, out_pc, out_instr;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
    );

    typedef struct {logic [31:0] pc; bit stale;} tag_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    typedef struct {logic [31:0] addr; int due;} mreq_t;

    tag_t        oq[$];
    ent_t        fq[$];
    mreq_t       mq[$];
    logic [31:0] delivered[$];
    logic [31:0] m_pc = RPC;
    int          n_chk = 0, n_fail = 0, cyc = 0, lat = 1;
    bit          resp_en = 1, stray = 0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // one clock cycle: drive inputs, compare against the model, then advance the model
    task automatic step(input logic rst, input logic rd, input logic [31:0] rpc, input logic gnt, input logic rdy);
        bit   rv, m_req, m_valid, grant;
        tag_t t;
        @(negedge clk);
        cyc++;
        rv = !rst && resp_en && mq.size() > 0 && cyc >= mq[0].due;
        reset = rst; redirect = rd; redirect_pc = rpc; imem_gnt = gnt; out_ready = rdy;
        imem_rvalid = rv || stray;
        imem_rdata = rv ? mem_word(mq[0].addr) : 32'hBAD0_BAD0;
        #1;
        m_req = !rst && !rd && oq.size() < MO && oq.size() + fq.size() < FD;
        m_valid = !rst && !rd && fq.size() != 0;
        s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_pc = out_pc; s_instr = out_instr;
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (!rst) chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_pc", out_pc, fq[0].pc);
            chk("out_instr", out_instr, fq[0].instr);
        end else if (rst) begin
            chk("rst_out_pc", out_pc, 32'd0);
            chk("rst_out_instr", out_instr, 32'd0);
        end
        if (rst) begin
            oq.delete(); fq.delete(); mq.delete();
            m_pc = RPC;
        end else begin
            grant = m_req && gnt;
            if (m_valid && rdy) begin
                delivered.push_back(fq[0].pc);
                void'(fq.pop_front());
            end
            if (imem_rvalid && oq.size() > 0) begin
                t = oq.pop_front();
                if (!t.stale && !rd) fq.push_back('{t.pc, imem_rdata});
            end
            if (rv) void'(mq.pop_front());
            if (rd) begin
                foreach (oq[i]) oq[i].stale = 1'b1;
                fq.delete();
                m_pc = {rpc[31:2], 2'b00};
            end
            if (grant) begin
                oq.push_back('{m_pc, 1'b0});
                mq.push_back('{m_pc, cyc + lat});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        logic [6:0] gp = 7'b1011011;
        logic [4:0] rp = 5'b11010;
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0; out_ready = 1'b0;
        step(1, 0, 0, 1, 1);
        chk("h_rst_req", 32'(s_req), 32'd0);
        chk("h_rst_valid", 32'(s_valid), 32'd0);
        stray = 1;
        step(0, 0, 0, 1, 1);
        stray = 0;
        chk("h_first_req", 32'(s_req), 32'd1);
        chk("h_first_addr", s_addr, 32'h0000_3000);
        step(0, 0, 0, 1, 1);
        chk("h_second_addr", s_addr, 32'h0000_3004);
        chk("h_no_valid_yet", 32'(s_valid), 32'd0);
        step(0, 0, 0, 1, 1);
        chk("h_first_valid", 32'(s_valid), 32'd1);
        chk("h_first_pc", s_pc, 32'h0000_3000);
        chk("h_first_instr", s_instr, 32'h6A5A_CFFF);
        repeat (12) step(0, 0, 0, 1, 1);
        chk("h_seq0", delivered[0], 32'h0000_3000);
        chk("h_seq1", delivered[1], 32'h0000_3004);
        chk("h_seq2", delivered[2], 32'h0000_3008);
        delivered.delete();
        repeat (10) step(0, 0, 0, 1, 0);
        chk("h_stall_req", 32'(s_req), 32'd0);
        chk("h_stall_valid", 32'(s_valid), 32'd1);
        repeat (10) step(0, 0, 0, 1, 1);
        chk("h_stall_cnt", 32'(delivered.size() >= 5), 32'd1);
        foreach (delivered[i]) chk("h_stall_order", delivered[i], delivered[0] + 32'(4 * i));
        resp_en = 0;
        repeat (5) step(0, 0, 0, 1, 1);
        chk("h_blocked_req", 32'(s_req), 32'd0);
        step(0, 1, 32'h0000_3040, 1, 1);
        chk("h_redir_valid", 32'(s_valid), 32'd0);
        chk("h_redir_req", 32'(s_req), 32'd0);
        resp_en = 1;
        delivered.delete();
        step(0, 0, 0, 1, 1);
        chk("h_redir_addr", s_addr, 32'h0000_3040);
        repeat (10) step(0, 0, 0, 1, 1);
        chk("h_redir_pc0", delivered[0], 32'h0000_3040);
        chk("h_redir_pc1", delivered[1], 32'h0000_3044);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (fq.size() > 0 && mq.size() > 0 && mq[0].due <= cyc + 1) found = 1;
            else step(0, 0, 0, 1, 1);
        end
        chk("h_r37_setup", 32'(found), 32'd1);
        step(0, 1, 32'h0000_3100, 1, 1);
        chk("h_r37_valid", 32'(s_valid), 32'd0);
        chk("h_r37_rvalid", 32'(imem_rvalid), 32'd1);
        step(0, 0, 0, 1, 1);
        chk("h_r37_flushed", 32'(s_valid), 32'd0);
        repeat (6) step(0, 0, 0, 1, 1);
        step(0, 1, 32'hFFFF_FFFC, 1, 1);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(0, 0, 0, 1, 1);
            found = s_req;
        end
        chk("h_wrap_req", 32'(found), 32'd1);
        chk("h_wrap_addr0", s_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 1);
        chk("h_wrap_addr1", s_addr, 32'h0000_0000);
        repeat (4) step(0, 0, 0, 1, 1);
        step(0, 1, 32'h0000_3043, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("h_align_addr", s_addr, 32'h0000_3040);
        lat = 2;
        for (int i = 0; i < 40; i++) step(0, (i == 23), 32'h0000_5008, gp[i % 7], rp[i % 5]);
        lat = 1;
        repeat (6) step(0, 0, 0, 1, 0);
        step(1, 1, 32'h0000_7000, 1, 1);
        chk("h_rst2_valid", 32'(s_valid), 32'd0);
        chk("h_rst2_req", 32'(s_req), 32'd0);
        step(0, 0, 0, 1, 1);
        chk("h_rst2_next_req", 32'(s_req), 32'd1);
        chk("h_rst2_next_addr", s_addr, 32'h0000_3000);
        chk("h_rst2_next_valid", 32'(s_valid), 32'd0);
        repeat (6) step(0, 0, 0, 1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
